// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid handshake plus the
// push port into the instruction queue FIFO. The fetch unit is the master.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [XLEN-1:0]   imem_rdata;
  logic              fifo_wr_en;
  logic [2*XLEN-1:0] fifo_wr_data;
  logic              fifo_full;

  modport master (
    output imem_req, imem_addr, fifo_wr_en, fifo_wr_data,
    input  imem_gnt, imem_rvalid, imem_rdata, fifo_full
  );

  modport slave (
    input  imem_req, imem_addr, fifo_wr_en, fifo_wr_data,
    output imem_gnt, imem_rvalid, imem_rdata, fifo_full
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one outstanding imem
// request at a time, pushes {pc, instr} into the instruction queue, and
// squashes the in-flight fetch on a redirect.
// Optional macro FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_stall
// counters.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus,
  output logic            fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   hold_q, hold_d;
  logic              push;
  logic [2*XLEN-1:0] wr_data;

  // State, PC and held-instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, PC update and FIFO push decode; redirect overrides everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    push    = 1'b0;
    wr_data = '0;
    case (state_q)
      S_REQ: begin
        if (bus.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        wr_data = {pc_q, bus.imem_rdata};
        if (bus.imem_rvalid) begin
          if (!bus.fifo_full) begin
            push    = 1'b1;
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
          end else begin
            // Queue is full: park the word rather than stall memory
            hold_d  = bus.imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        wr_data = {pc_q, hold_q};
        if (!bus.fifo_full) begin
          push    = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      push = 1'b0;
      pc_d = redirect_pc & ALIGN_MASK;
      case (state_q)
        S_REQ:   state_d = bus.imem_gnt    ? S_DROP : S_REQ;
        S_WAIT:  state_d = bus.imem_rvalid ? S_REQ  : S_DROP;
        S_DROP:  state_d = bus.imem_rvalid ? S_REQ  : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Request is gated by rst_n so it drops the instant reset asserts
  assign bus.imem_req     = rst_n & (state_q == S_REQ);
  assign bus.imem_addr    = pc_q;
  assign bus.fifo_wr_en   = push;
  assign bus.fifo_wr_data = wr_data;
  assign fetch_busy       = (state_q != S_REQ);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;
  logic        stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign stall = (state_q == S_HOLD) ||
                 ((state_q == S_WAIT) && bus.imem_rvalid && bus.fifo_full);

  // Saturating counters for pushes and full-queue stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push)  perf_fetched_q <= sat_inc(perf_fetched_q);
      if (stall) perf_stall_q   <= sat_inc(perf_stall_q);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed walk through the fetch scenarios, then
// randomized memory/FIFO/redirect traffic checked against a transaction-level
// model (outstanding request, squash pending, parked word, expected PC).
module tb_fetch_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
`endif

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_busy     (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_out;   // a granted request awaits its response
  logic        m_sq;    // that response must be thrown away
  logic        m_hv;    // a fetched word is parked waiting for FIFO room
  logic [31:0] m_hold;

  logic [63:0] last_push;
  int          n_push;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 1'b0; m_sq = 1'b0; m_hv = 1'b0; m_hold = 32'h0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model
  task automatic cyc(input logic gnt, input logic rv, input logic [31:0] rd,
                     input logic full, input logic red, input logic [31:0] rpc);
    logic        e_req, e_push;
    logic [63:0] e_data;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.fifo_full   = full;
    redirect_valid  = red;
    redirect_pc     = rpc;
    e_req  = !m_out && !m_hv;
    e_push = 1'b0;
    e_data = '0;
    if (!red && !full) begin
      if (m_hv) begin
        e_push = 1'b1; e_data = {m_pc, m_hold};
      end else if (m_out && !m_sq && rv) begin
        e_push = 1'b1; e_data = {m_pc, rd};
      end
    end
    #1;
    chk("imem_req", {63'b0, bus.imem_req}, {63'b0, e_req});
    if (e_req) chk("imem_addr", {32'b0, bus.imem_addr}, {32'b0, m_pc});
    chk("fetch_busy", {63'b0, fetch_busy}, {63'b0, !e_req});
    chk("fifo_wr_en", {63'b0, bus.fifo_wr_en}, {63'b0, e_push});
    if (e_push) chk("fifo_wr_data", bus.fifo_wr_data, e_data);
    if (bus.fifo_wr_en) begin
      last_push = bus.fifo_wr_data;
      n_push++;
    end
    @(posedge clk);
    if (red) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_hv = 1'b0;
      if (m_out) begin
        if (rv) begin m_out = 1'b0; m_sq = 1'b0; end
        else m_sq = 1'b1;
      end else if (e_req && gnt) begin
        m_out = 1'b1; m_sq = 1'b1;
      end
    end else if (m_hv) begin
      if (!full) begin m_hv = 1'b0; m_pc = m_pc + 32'd4; end
    end else if (m_out) begin
      if (rv) begin
        m_out = 1'b0;
        if (m_sq) m_sq = 1'b0;
        else if (full) begin m_hv = 1'b1; m_hold = rd; end
        else m_pc = m_pc + 32'd4;
      end
    end else if (gnt) begin
      m_out = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic        g, r, f, rd_en;
    logic [31:0] tgt;
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.fifo_full = 1'b0;
    last_push = '0; n_push = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {63'b0, bus.imem_req}, 64'd0);
    chk("rst_addr", {32'b0, bus.imem_addr}, 64'd0);
    chk("rst_wr_en", {63'b0, bus.fifo_wr_en}, 64'd0);
    chk("rst_wr_data", bus.fifo_wr_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three back-to-back fetches, immediate grant, response next cycle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_0013, 0, 0, 0);
    chk("push0", last_push, 64'h00000000_00000013);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0010_0093, 0, 0, 0);
    chk("push1", last_push, 64'h00000004_00100093);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0020_0113, 0, 0, 0);
    chk("push2", last_push, 64'h00000008_00200113);
    chk("push_cnt3", 64'(n_push), 64'd3);

    // Response arrives into a full queue: park it, release after 3 cycles
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("hold_busy", {63'b0, fetch_busy}, 64'd1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_push", last_push, 64'h0000000C_DEADBEEF);
    chk("push_cnt4", 64'(n_push), 64'd4);
    #1 chk("addr_after_hold", {32'b0, bus.imem_addr}, 64'h10);
    @(negedge clk);

    // Redirect during WAIT: in-flight response is discarded
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0103);
    cyc(0, 1, 32'h1111_1111, 0, 0, 0);
    chk("squash_cnt", 64'(n_push), 64'd4);
    #1 chk("redir_addr", {32'b0, bus.imem_addr}, 64'h100);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h2222_2222, 0, 0, 0);
    chk("redir_push", last_push, 64'h00000100_22222222);

    // Redirect coincident with grant: that response is dropped
    cyc(1, 0, 0, 0, 1, 32'h0000_0200);
    chk("drop_busy", {63'b0, fetch_busy}, 64'd1);
    cyc(0, 1, 32'h3333_3333, 0, 0, 0);
    chk("drop_cnt", 64'(n_push), 64'd5);
    #1 chk("drop_addr", {32'b0, bus.imem_addr}, 64'h200);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);

    // Reset mid-WAIT: outputs return before any clock edge
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {63'b0, bus.imem_req}, 64'd0);
    chk("mid_rst_addr", {32'b0, bus.imem_addr}, 64'd0);
    chk("mid_rst_busy", {63'b0, fetch_busy}, 64'd0);
    chk("mid_rst_wr_en", {63'b0, bus.fifo_wr_en}, 64'd0);
    chk("mid_rst_wr_data", bus.fifo_wr_data, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hCAFE_F00D, 0, 0, 0);
    chk("wrap_push", last_push, 64'hFFFFFFFC_CAFEF00D);
    #1 chk("wrap_addr", {32'b0, bus.imem_addr}, 64'h0);
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      g = (!m_out && !m_hv) ? ($urandom_range(0, 9) < 7) : 1'b0;
      r = m_out ? ($urandom_range(0, 9) < 6) : 1'b0;
      f = ($urandom_range(0, 9) < 3);
      rd_en = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(g, r, $urandom, f, rd_en, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
